// File: rtl/lsb_mem_ctrl_if.sv
// LSB memc request bus plus byte-wide RAM/IO port, bundled for lsb_mem_ctrl.
// master: LSB / top-level side; slave: the memory controller.
interface lsb_mem_ctrl_if #(
  parameter int unsigned ADDR_WIDTH = 32
);
  logic                  rdy;
  logic                  memc_en;
  logic                  memc_rw;
  logic [ADDR_WIDTH-1:0] memc_addr;
  logic [2:0]            memc_len;
  logic [31:0]           memc_w_data;
  logic                  memc_done;
  logic [31:0]           memc_r_data;
  logic [7:0]            mem_din;
  logic [7:0]            mem_dout;
  logic [ADDR_WIDTH-1:0] mem_a;
  logic                  mem_wr;
  logic                  io_buffer_full;

  modport master (
    output rdy, memc_en, memc_rw, memc_addr, memc_len, memc_w_data,
    output mem_din, io_buffer_full,
    input  memc_done, memc_r_data, mem_dout, mem_a, mem_wr
  );

  modport slave (
    input  rdy, memc_en, memc_rw, memc_addr, memc_len, memc_w_data,
    input  mem_din, io_buffer_full,
    output memc_done, memc_r_data, mem_dout, mem_a, mem_wr
  );
endinterface

// File: rtl/lsb_mem_ctrl.sv
// Memory-side responder for the LSB: serialises 1/2/4-byte loads and stores
// onto the byte-wide RAM/IO bus (little-endian) and pulses memc_done.
// Optional macro MEMC_IO_STALL_EN: hold IO-space stores in IDLE while the
// IO output buffer is full.
module lsb_mem_ctrl #(
  parameter int unsigned          ADDR_WIDTH = 32,
  parameter logic [ADDR_WIDTH-1:0] IO_BASE   = ADDR_WIDTH'(32'h0003_0000)
) (
  input logic           clk,
  input logic           rst,
  lsb_mem_ctrl_if.slave bus
);

  localparam int unsigned CNT_W  = 3;
  localparam int unsigned DATA_W = 32;

  typedef enum logic [1:0] {S_IDLE, S_READ, S_WRITE, S_DONE} state_e;

  state_e              state_q, state_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [CNT_W-1:0]    len_q, len_d;
  logic [DATA_W-1:0]   wdata_q, wdata_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic                rstall_q, rstall_d;
  logic [ADDR_WIDTH-1:0] mem_a_q, mem_a_d;
  logic [7:0]          dout_q, dout_d;
  logic                wr_q, wr_d;
  logic                done_q, done_d;
  logic [DATA_W-1:0]   rbuf_q, rbuf_d;
  logic [DATA_W-1:0]   rdata_q, rdata_d;

  logic [CNT_W-1:0]    len_norm_c;
  logic [CNT_W-1:0]    cnt_nxt_c;
  logic [1:0]          rd_idx_c;
  logic                io_block_c;

  // Any length other than 1 or 2 is handled as a full word.
  always_comb begin
    len_norm_c = CNT_W'(4);
    if (bus.memc_len == 3'd1)      len_norm_c = CNT_W'(1);
    else if (bus.memc_len == 3'd2) len_norm_c = CNT_W'(2);
  end

  assign cnt_nxt_c = cnt_q + CNT_W'(1);
  assign rd_idx_c  = 2'(cnt_q - CNT_W'(1));

`ifdef MEMC_IO_STALL_EN
  assign io_block_c = bus.memc_rw && (bus.memc_addr >= IO_BASE) && bus.io_buffer_full;
`else
  logic unused_io_c;
  assign io_block_c  = 1'b0;
  assign unused_io_c = bus.io_buffer_full ^ (bus.memc_addr >= IO_BASE);
`endif

  // State and datapath registers; rst aborts any transfer in flight.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= S_IDLE;
      addr_q   <= '0;
      len_q    <= '0;
      wdata_q  <= '0;
      cnt_q    <= '0;
      rstall_q <= 1'b0;
      mem_a_q  <= '0;
      dout_q   <= '0;
      wr_q     <= 1'b0;
      done_q   <= 1'b0;
      rbuf_q   <= '0;
      rdata_q  <= '0;
    end else begin
      state_q  <= state_d;
      addr_q   <= addr_d;
      len_q    <= len_d;
      wdata_q  <= wdata_d;
      cnt_q    <= cnt_d;
      rstall_q <= rstall_d;
      mem_a_q  <= mem_a_d;
      dout_q   <= dout_d;
      wr_q     <= wr_d;
      done_q   <= done_d;
      rbuf_q   <= rbuf_d;
      rdata_q  <= rdata_d;
    end
  end

  // Next-state and datapath logic; rdy=0 freezes everything but the read-stall flag.
  always_comb begin
    state_d  = state_q;
    addr_d   = addr_q;
    len_d    = len_q;
    wdata_d  = wdata_q;
    cnt_d    = cnt_q;
    rstall_d = rstall_q;
    mem_a_d  = mem_a_q;
    dout_d   = dout_q;
    wr_d     = wr_q;
    done_d   = done_q;
    rbuf_d   = rbuf_q;
    rdata_d  = rdata_q;

    if (!bus.rdy) begin
      // RAM read data is lost across a stall, so a load restarts afterwards.
      if (state_q == S_READ) rstall_d = 1'b1;
    end else begin
      unique case (state_q)
        S_IDLE: begin
          if (bus.memc_en && !io_block_c) begin
            addr_d   = bus.memc_addr;
            len_d    = len_norm_c;
            wdata_d  = bus.memc_w_data;
            cnt_d    = '0;
            rstall_d = 1'b0;
            rbuf_d   = '0;
            mem_a_d  = bus.memc_addr;
            if (bus.memc_rw) begin
              dout_d  = bus.memc_w_data[7:0];
              wr_d    = 1'b1;
              state_d = S_WRITE;
            end else begin
              state_d = S_READ;
            end
          end
        end
        S_READ: begin
          if (!bus.memc_en) begin
            wr_d    = 1'b0;
            state_d = S_IDLE;
          end else if (rstall_q) begin
            rstall_d = 1'b0;
            cnt_d    = '0;
            rbuf_d   = '0;
            mem_a_d  = addr_q;
          end else begin
            // mem_din lags the address by one cycle, so byte cnt-1 is on the bus now.
            if (cnt_q != '0) rbuf_d[{rd_idx_c, 3'b000} +: 8] = bus.mem_din;
            if (cnt_q == len_q) begin
              rdata_d = rbuf_d;
              done_d  = 1'b1;
              state_d = S_DONE;
            end else begin
              cnt_d = cnt_nxt_c;
              if (cnt_nxt_c < len_q) mem_a_d = addr_q + ADDR_WIDTH'(cnt_nxt_c);
            end
          end
        end
        S_WRITE: begin
          if (!bus.memc_en) begin
            wr_d    = 1'b0;
            state_d = S_IDLE;
          end else if (cnt_nxt_c < len_q) begin
            cnt_d   = cnt_nxt_c;
            mem_a_d = addr_q + ADDR_WIDTH'(cnt_nxt_c);
            dout_d  = wdata_q[{cnt_nxt_c[1:0], 3'b000} +: 8];
          end else begin
            wr_d    = 1'b0;
            done_d  = 1'b1;
            state_d = S_DONE;
          end
        end
        S_DONE: begin
          done_d  = 1'b0;
          state_d = S_IDLE;
        end
        default: state_d = S_IDLE;
      endcase
    end
  end

  assign bus.memc_done   = done_q;
  assign bus.memc_r_data = rdata_q;
  assign bus.mem_a       = mem_a_q;
  assign bus.mem_dout    = dout_q;
  assign bus.mem_wr      = wr_q & bus.rdy;

endmodule

// File: tb/tb_lsb_mem_ctrl.sv
// Scoreboard bench for lsb_mem_ctrl: driver pushes expected completions and
// writes, independent monitors pop and compare them as the DUT produces them.
module tb_lsb_mem_ctrl;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  lsb_mem_ctrl_if #(.ADDR_WIDTH(32)) io ();

  lsb_mem_ctrl #(.ADDR_WIDTH(32), .IO_BASE(32'h0003_0000)) dut (
    .clk (clk),
    .rst (rst),
    .bus (io)
  );

  typedef struct {
    logic        is_load;
    logic [31:0] rdata;
    int unsigned at;
  } exp_t;

  typedef struct {
    logic [31:0] a;
    logic [7:0]  d;
  } wr_t;

  exp_t        exp_q[$];
  wr_t         wq[$];
  logic [7:0]  ram [logic [31:0]];
  int unsigned cyc = 0;
  int          n_chk = 0;
  int          n_pass = 0;
  int          n_done = 0;
  int          n_req = 0;

  function automatic logic [7:0] ram_rd(input logic [31:0] a);
    return ram.exists(a) ? ram[a] : 8'h00;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
  endtask

  task automatic fail(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
  endtask

  always @(posedge clk) cyc <= cyc + 1;

  // Byte RAM: registered read of the previous cycle's address.
  always @(posedge clk) begin
    if (io.mem_wr) ram[io.mem_a] = io.mem_dout;
    io.mem_din <= ram_rd(io.mem_a);
  end

  // Completion monitor.
  always @(negedge clk) begin
    exp_t e;
    if (!rst && io.memc_done) begin
      n_done++;
      if (exp_q.size() == 0) begin
        fail("spurious_done", 32'd1, 32'd0);
      end else begin
        e = exp_q.pop_front();
        chk("done_cycle", cyc, e.at);
        if (e.is_load) chk("load_data", io.memc_r_data, e.rdata);
      end
    end
  end

  // Write monitor: every cycle with mem_wr high is one RAM write.
  always @(negedge clk) begin
    wr_t w;
    if (!rst && io.mem_wr) begin
      if (wq.size() == 0) begin
        fail("spurious_write_addr", io.mem_a, 32'hxxxx_xxxx);
      end else begin
        w = wq.pop_front();
        chk("write_addr", io.mem_a, w.a);
        chk("write_data", 32'(io.mem_dout), 32'(w.d));
      end
    end
  end

  task automatic push_wr(input logic [31:0] a, input logic [7:0] d);
    wr_t w;
    w.a = a;
    w.d = d;
    wq.push_back(w);
  endtask

  task automatic start_req(input logic rw, input logic [31:0] a, input logic [2:0] len,
                           input logic [31:0] wd, input logic [31:0] erd,
                           input int unsigned lat, input bit push);
    exp_t e;
    @(negedge clk);
    io.memc_en     = 1'b1;
    io.memc_rw     = rw;
    io.memc_addr   = a;
    io.memc_len    = len;
    io.memc_w_data = wd;
    if (push) begin
      e.is_load = !rw;
      e.rdata   = erd;
      e.at      = cyc + 1 + lat;
      exp_q.push_back(e);
      n_req++;
    end
  endtask

  task automatic wait_done(input string name);
    bit seen = 1'b0;
    for (int k = 0; k < 60 && !seen; k++) begin
      @(negedge clk);
      if (io.memc_done) seen = 1'b1;
    end
    io.memc_en = 1'b0;
    if (!seen) fail({name, "_timeout"}, 32'd0, 32'd1);
  endtask

  task automatic req(input logic rw, input logic [31:0] a, input logic [2:0] len,
                     input logic [31:0] wd, input logic [31:0] erd,
                     input int unsigned lat, input string name);
    start_req(rw, a, len, wd, erd, lat, 1'b1);
    wait_done(name);
  endtask

  initial begin
    rst               = 1'b1;
    io.rdy            = 1'b1;
    io.memc_en        = 1'b0;
    io.memc_rw        = 1'b0;
    io.memc_addr      = '0;
    io.memc_len       = 3'd1;
    io.memc_w_data    = '0;
    io.io_buffer_full = 1'b0;
    ram[32'h100] = 8'h11; ram[32'h101] = 8'h22; ram[32'h102] = 8'h33;
    ram[32'h103] = 8'h44; ram[32'h104] = 8'h99; ram[32'h204] = 8'h5A;

    #1;
    chk("rst_done",   32'(io.memc_done), 32'd0);
    chk("rst_r_data", io.memc_r_data,    32'd0);
    chk("rst_mem_a",  io.mem_a,          32'd0);
    chk("rst_dout",   32'(io.mem_dout),  32'd0);
    chk("rst_wr",     32'(io.mem_wr),    32'd0);
    repeat (3) @(negedge clk);
    rst = 1'b0;

    // Word load.
    req(1'b0, 32'h100, 3'd4, 32'h0, 32'h4433_2211, 5, "load_word");

    // Half store, neighbour byte untouched.
    push_wr(32'h202, 8'hEF); push_wr(32'h203, 8'hBE);
    req(1'b1, 32'h202, 3'd2, 32'hDEAD_BEEF, 32'h0, 2, "store_half");
    @(negedge clk);
    chk("ram_202", 32'(ram_rd(32'h202)), 32'hEF);
    chk("ram_203", 32'(ram_rd(32'h203)), 32'hBE);
    chk("ram_204", 32'(ram_rd(32'h204)), 32'h5A);

    // Byte load then back-to-back store and load.
    req(1'b0, 32'h202, 3'd1, 32'h0, 32'h0000_00EF, 2, "load_byte");
    push_wr(32'h300, 8'h77);
    req(1'b1, 32'h300, 3'd1, 32'h1234_5677, 32'h0, 1, "store_byte");
    req(1'b0, 32'h300, 3'd1, 32'h0, 32'h0000_0077, 2, "load_back");

    // Misaligned and odd lengths (0 and 3 behave as 4).
    req(1'b0, 32'h103, 3'd2, 32'h0, 32'h0000_9944, 3, "load_misaligned");
    req(1'b0, 32'h101, 3'd0, 32'h0, 32'h9944_3322, 5, "load_len0");
    req(1'b0, 32'h100, 3'd3, 32'h0, 32'h4433_2211, 5, "load_len3");

    // Abort a word load at A+2; previous load data must persist.
    start_req(1'b0, 32'h100, 3'd4, 32'h0, 32'h0, 0, 1'b0);
    @(negedge clk);
    @(negedge clk);
    io.memc_en = 1'b0;
    repeat (6) @(negedge clk);
    chk("abort_r_data", io.memc_r_data, 32'h4433_2211);
    chk("abort_wr",     32'(io.mem_wr), 32'd0);
    req(1'b0, 32'h202, 3'd2, 32'h0, 32'h0000_BEEF, 3, "load_after_abort");

    // Store word with rdy low for 3 edges after A+1.
    push_wr(32'h400, 8'h01); push_wr(32'h401, 8'h02);
    push_wr(32'h402, 8'h03); push_wr(32'h403, 8'h04);
    start_req(1'b1, 32'h400, 3'd4, 32'h0403_0201, 32'h0, 7, 1'b1);
    @(negedge clk);
    @(negedge clk);
    io.rdy = 1'b0;
    #1 chk("stall_wr_gated", 32'(io.mem_wr), 32'd0);
    repeat (3) @(negedge clk);
    io.rdy = 1'b1;
    wait_done("store_stall");

    // Half load with rdy low for 2 edges: restarts from byte 0.
    start_req(1'b0, 32'h400, 3'd2, 32'h0, 32'h0000_0201, 7, 1'b1);
    @(negedge clk);
    @(negedge clk);
    io.rdy = 1'b0;
    repeat (2) @(negedge clk);
    io.rdy = 1'b1;
    wait_done("load_stall");

    // Address wrap-around.
    push_wr(32'hFFFF_FFFF, 8'hAB); push_wr(32'h0000_0000, 8'hCD);
    req(1'b1, 32'hFFFF_FFFF, 3'd2, 32'h0000_CDAB, 32'h0, 2, "store_wrap");
    req(1'b0, 32'hFFFF_FFFF, 3'd2, 32'h0, 32'h0000_CDAB, 3, "load_wrap");

    // IO-space store while the IO buffer is full.
    io.io_buffer_full = 1'b1;
    push_wr(32'h0003_0000, 8'hAB);
`ifdef MEMC_IO_STALL_EN
    start_req(1'b1, 32'h0003_0000, 3'd1, 32'h0000_00AB, 32'h0, 6, 1'b1);
    repeat (5) @(negedge clk);
    io.io_buffer_full = 1'b0;
    wait_done("io_store");
`else
    req(1'b1, 32'h0003_0000, 3'd1, 32'h0000_00AB, 32'h0, 1, "io_store");
    io.io_buffer_full = 1'b0;
`endif
    chk("ram_io", 32'(ram_rd(32'h0003_0000)), 32'hAB);

    repeat (4) @(negedge clk);
    chk("done_count",   32'(n_done),        32'(n_req));
    chk("exp_q_empty",  32'(exp_q.size()),  32'd0);
    chk("wr_q_empty",   32'(wq.size()),     32'd0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
